// File: rtl/cache_pkg.sv
// Shared types and field positions for the two-way set-associative cache controller.
package cache_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 28;
    localparam int IDX_W   = 2;
    localparam int SETS    = 1 << IDX_W;
    localparam int TAG_LSB = 4;
    localparam int IDX_LSB = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG_RD,
        S_CMP,
        S_WB,
        S_REFILL_REQ,
        S_REFILL_WAIT,
        S_RESP
    } state_t;

    // Word-aligned line address built from a tag and a set index.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [IDX_W-1:0] idx);
        return {tag, idx, 2'b00};
    endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set LRU bit. The stored bit names the way to evict next.
module cache_lru
    import cache_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_index,
    input  logic             i_update,
    input  logic             i_used_way,
    output logic             o_victim
);

    logic [SETS-1:0] r_lru;

    // On a hit or fill, point the set's LRU bit at the way that was not used.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lru <= '0;
        end else if (i_update) begin
            r_lru[i_index] <= ~i_used_way;
        end
    end

    assign o_victim = r_lru[i_index];

endmodule

// File: rtl/cache_ctrl.sv
// Two-way set-associative write-back cache controller driving an external tag/data array.
//
// state        | meaning
// S_IDLE       | ready for a CPU request
// S_TAG_RD     | array read in flight for the latched index
// S_CMP        | tag compare, hit handling, victim choice
// S_WB         | writing a dirty victim back to memory
// S_REFILL_REQ | issuing the refill read
// S_REFILL_WAIT| waiting for refill data
// S_RESP       | one-cycle response to the CPU
module cache_ctrl
    import cache_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cpu_req_valid,
    input  logic                i_cpu_req_write,
    input  logic [ADDR_W-1:0]   i_cpu_req_addr,
    input  logic [DATA_W-1:0]   i_cpu_req_wdata,
    output logic                o_cpu_req_ready,
    output logic                o_cpu_resp_valid,
    output logic [DATA_W-1:0]   o_cpu_resp_rdata,
    output logic                o_mem_req_valid,
    output logic                o_mem_req_write,
    output logic [ADDR_W-1:0]   o_mem_req_addr,
    output logic [DATA_W-1:0]   o_mem_req_wdata,
    input  logic                i_mem_req_ready,
    input  logic                i_mem_resp_valid,
    input  logic [DATA_W-1:0]   i_mem_resp_rdata,
    output logic [IDX_W-1:0]    o_arr_index,
    output logic                o_arr_write_en,
    output logic                o_arr_victim_way,
    output logic                o_arr_v_in,
    output logic                o_arr_dirty_in,
    output logic [TAG_W-1:0]    o_arr_tag_in,
    output logic [DATA_W-1:0]   o_arr_data_in,
    input  logic [1:0]          i_arr_v,
    input  logic [1:0]          i_arr_dirty,
    input  logic [2*TAG_W-1:0]  i_arr_tag,
    input  logic [2*DATA_W-1:0] i_arr_data
);

    state_t             r_state;
    logic               r_req_write;
    logic [TAG_W-1:0]   r_req_tag;
    logic [DATA_W-1:0]  r_req_wdata;
    logic               r_victim;

    logic               w_hit0;
    logic               w_hit1;
    logic               w_hit;
    logic               w_hit_way;
    logic [DATA_W-1:0]  w_hit_data;
    logic               w_lru_victim;
    logic               w_miss_way;
    logic               w_vic_dirty;
    logic [TAG_W-1:0]   w_vic_tag;
    logic [DATA_W-1:0]  w_vic_data;
    logic               w_lru_update;
    logic               w_lru_used;
    logic               w_unused_addr_lsb;

    // Byte offset bits carry no information for a word-aligned cache.
    assign w_unused_addr_lsb = ^i_cpu_req_addr[1:0];

    assign w_hit0     = i_arr_v[0] & (i_arr_tag[TAG_W-1:0] == r_req_tag);
    assign w_hit1     = i_arr_v[1] & (i_arr_tag[2*TAG_W-1:TAG_W] == r_req_tag);
    assign w_hit      = w_hit0 | w_hit1;
    assign w_hit_way  = ~w_hit0;
    assign w_hit_data = w_hit_way ? i_arr_data[2*DATA_W-1:DATA_W] : i_arr_data[DATA_W-1:0];

    // An empty way always beats the LRU choice; way0 is checked first.
    assign w_miss_way  = ~i_arr_v[0] ? 1'b0 : (~i_arr_v[1] ? 1'b1 : w_lru_victim);
    assign w_vic_dirty = i_arr_v[w_miss_way] & i_arr_dirty[w_miss_way];
    assign w_vic_tag   = w_miss_way ? i_arr_tag[2*TAG_W-1:TAG_W] : i_arr_tag[TAG_W-1:0];
    assign w_vic_data  = w_miss_way ? i_arr_data[2*DATA_W-1:DATA_W] : i_arr_data[DATA_W-1:0];

    // Array write port: decoded from the current state so a write lands in the same
    // cycle as the event that causes it (store in CMP, WB handshake, refill beat).
    always_comb begin
        o_arr_write_en   = 1'b0;
        o_arr_victim_way = 1'b0;
        o_arr_v_in       = 1'b0;
        o_arr_dirty_in   = 1'b0;
        o_arr_tag_in     = '0;
        o_arr_data_in    = '0;
        if (!i_rst) begin
            case (r_state)
                S_CMP: begin
                    if (r_req_write && w_hit) begin
                        o_arr_write_en   = 1'b1;
                        o_arr_victim_way = w_hit_way;
                        o_arr_v_in       = 1'b1;
                        o_arr_dirty_in   = 1'b1;
                        o_arr_tag_in     = r_req_tag;
                        o_arr_data_in    = r_req_wdata;
                    end else if (r_req_write && !w_vic_dirty) begin
                        o_arr_write_en   = 1'b1;
                        o_arr_victim_way = w_miss_way;
                        o_arr_v_in       = 1'b1;
                        o_arr_dirty_in   = 1'b1;
                        o_arr_tag_in     = r_req_tag;
                        o_arr_data_in    = r_req_wdata;
                    end
                end
                S_WB: begin
                    if (r_req_write && i_mem_req_ready) begin
                        o_arr_write_en   = 1'b1;
                        o_arr_victim_way = r_victim;
                        o_arr_v_in       = 1'b1;
                        o_arr_dirty_in   = 1'b1;
                        o_arr_tag_in     = r_req_tag;
                        o_arr_data_in    = r_req_wdata;
                    end
                end
                S_REFILL_WAIT: begin
                    if (i_mem_resp_valid) begin
                        o_arr_write_en   = 1'b1;
                        o_arr_victim_way = r_victim;
                        o_arr_v_in       = 1'b1;
                        o_arr_dirty_in   = 1'b0;
                        o_arr_tag_in     = r_req_tag;
                        o_arr_data_in    = i_mem_resp_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every hit or fill touches the set; a store hit is both, with the same way.
    always_comb begin
        w_lru_update = o_arr_write_en | ((r_state == S_CMP) & w_hit & ~i_rst);
        w_lru_used   = ((r_state == S_CMP) && w_hit) ? w_hit_way : o_arr_victim_way;
    end

    cache_lru u_lru (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_index    (o_arr_index),
        .i_update   (w_lru_update),
        .i_used_way (w_lru_used),
        .o_victim   (w_lru_victim)
    );

    // Main controller FSM with registered CPU/memory-side outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= S_IDLE;
            r_req_write      <= 1'b0;
            r_req_tag        <= '0;
            r_req_wdata      <= '0;
            r_victim         <= 1'b0;
            o_arr_index      <= '0;
            o_cpu_req_ready  <= 1'b1;
            o_cpu_resp_valid <= 1'b0;
            o_cpu_resp_rdata <= '0;
            o_mem_req_valid  <= 1'b0;
            o_mem_req_write  <= 1'b0;
            o_mem_req_addr   <= '0;
            o_mem_req_wdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cpu_req_valid && o_cpu_req_ready) begin
                        r_req_write     <= i_cpu_req_write;
                        r_req_tag       <= i_cpu_req_addr[TAG_LSB +: TAG_W];
                        r_req_wdata     <= i_cpu_req_wdata;
                        o_arr_index     <= i_cpu_req_addr[IDX_LSB +: IDX_W];
                        o_cpu_req_ready <= 1'b0;
                        r_state         <= S_TAG_RD;
                    end
                end
                S_TAG_RD: begin
                    r_state <= S_CMP;
                end
                S_CMP: begin
                    if (w_hit) begin
                        o_cpu_resp_valid <= 1'b1;
                        o_cpu_resp_rdata <= r_req_write ? '0 : w_hit_data;
                        r_state          <= S_RESP;
                    end else begin
                        r_victim <= w_miss_way;
                        if (w_vic_dirty) begin
                            o_mem_req_valid <= 1'b1;
                            o_mem_req_write <= 1'b1;
                            o_mem_req_addr  <= line_addr(w_vic_tag, o_arr_index);
                            o_mem_req_wdata <= w_vic_data;
                            r_state         <= S_WB;
                        end else if (r_req_write) begin
                            o_cpu_resp_valid <= 1'b1;
                            o_cpu_resp_rdata <= '0;
                            r_state          <= S_RESP;
                        end else begin
                            o_mem_req_valid <= 1'b1;
                            o_mem_req_write <= 1'b0;
                            o_mem_req_addr  <= line_addr(r_req_tag, o_arr_index);
                            o_mem_req_wdata <= '0;
                            r_state         <= S_REFILL_REQ;
                        end
                    end
                end
                S_WB: begin
                    if (i_mem_req_ready) begin
                        if (r_req_write) begin
                            o_mem_req_valid  <= 1'b0;
                            o_mem_req_write  <= 1'b0;
                            o_mem_req_addr   <= '0;
                            o_mem_req_wdata  <= '0;
                            o_cpu_resp_valid <= 1'b1;
                            o_cpu_resp_rdata <= '0;
                            r_state          <= S_RESP;
                        end else begin
                            o_mem_req_write <= 1'b0;
                            o_mem_req_addr  <= line_addr(r_req_tag, o_arr_index);
                            o_mem_req_wdata <= '0;
                            r_state         <= S_REFILL_REQ;
                        end
                    end
                end
                S_REFILL_REQ: begin
                    if (i_mem_req_ready) begin
                        o_mem_req_valid <= 1'b0;
                        o_mem_req_addr  <= '0;
                        r_state         <= S_REFILL_WAIT;
                    end
                end
                S_REFILL_WAIT: begin
                    if (i_mem_resp_valid) begin
                        o_cpu_resp_valid <= 1'b1;
                        o_cpu_resp_rdata <= i_mem_resp_rdata;
                        r_state          <= S_RESP;
                    end
                end
                S_RESP: begin
                    o_cpu_resp_valid <= 1'b0;
                    o_cpu_resp_rdata <= '0;
                    o_cpu_req_ready  <= 1'b1;
                    r_state          <= S_IDLE;
                end
                default: begin
                    r_state         <= S_IDLE;
                    o_cpu_req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: external array and memory models, directed vectors and random traffic
// checked against a line-level cache model.
module tb_cache_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_cpu_req_valid = 1'b0;
    logic        i_cpu_req_write = 1'b0;
    logic [31:0] i_cpu_req_addr = '0;
    logic [31:0] i_cpu_req_wdata = '0;
    logic        o_cpu_req_ready;
    logic        o_cpu_resp_valid;
    logic [31:0] o_cpu_resp_rdata;
    logic        o_mem_req_valid;
    logic        o_mem_req_write;
    logic [31:0] o_mem_req_addr;
    logic [31:0] o_mem_req_wdata;
    logic        i_mem_req_ready = 1'b0;
    logic        i_mem_resp_valid = 1'b0;
    logic [31:0] i_mem_resp_rdata = '0;
    logic [1:0]  o_arr_index;
    logic        o_arr_write_en;
    logic        o_arr_victim_way;
    logic        o_arr_v_in;
    logic        o_arr_dirty_in;
    logic [27:0] o_arr_tag_in;
    logic [31:0] o_arr_data_in;
    logic [1:0]  i_arr_v;
    logic [1:0]  i_arr_dirty;
    logic [55:0] i_arr_tag;
    logic [63:0] i_arr_data;

    always #5 i_clk = ~i_clk;

    cache_ctrl dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_cpu_req_valid  (i_cpu_req_valid),
        .i_cpu_req_write  (i_cpu_req_write),
        .i_cpu_req_addr   (i_cpu_req_addr),
        .i_cpu_req_wdata  (i_cpu_req_wdata),
        .o_cpu_req_ready  (o_cpu_req_ready),
        .o_cpu_resp_valid (o_cpu_resp_valid),
        .o_cpu_resp_rdata (o_cpu_resp_rdata),
        .o_mem_req_valid  (o_mem_req_valid),
        .o_mem_req_write  (o_mem_req_write),
        .o_mem_req_addr   (o_mem_req_addr),
        .o_mem_req_wdata  (o_mem_req_wdata),
        .i_mem_req_ready  (i_mem_req_ready),
        .i_mem_resp_valid (i_mem_resp_valid),
        .i_mem_resp_rdata (i_mem_resp_rdata),
        .o_arr_index      (o_arr_index),
        .o_arr_write_en   (o_arr_write_en),
        .o_arr_victim_way (o_arr_victim_way),
        .o_arr_v_in       (o_arr_v_in),
        .o_arr_dirty_in   (o_arr_dirty_in),
        .o_arr_tag_in     (o_arr_tag_in),
        .o_arr_data_in    (o_arr_data_in),
        .i_arr_v          (i_arr_v),
        .i_arr_dirty      (i_arr_dirty),
        .i_arr_tag        (i_arr_tag),
        .i_arr_data       (i_arr_data)
    );

    // ---------------- external tag/data array (synchronous read) ----------------
    logic        tb_clr = 1'b0;
    logic [1:0]  a_v   [4];
    logic [1:0]  a_d   [4];
    logic [27:0] a_tag [4][2];
    logic [31:0] a_data[4][2];

    always @(posedge i_clk) begin
        if (tb_clr) begin
            for (int s = 0; s < 4; s++) begin
                a_v[s] <= 2'b00;
                a_d[s] <= 2'b00;
            end
        end else if (o_arr_write_en) begin
            a_v[o_arr_index][o_arr_victim_way]    <= o_arr_v_in;
            a_d[o_arr_index][o_arr_victim_way]    <= o_arr_dirty_in;
            a_tag[o_arr_index][o_arr_victim_way]  <= o_arr_tag_in;
            a_data[o_arr_index][o_arr_victim_way] <= o_arr_data_in;
        end
        i_arr_v     <= a_v[o_arr_index];
        i_arr_dirty <= a_d[o_arr_index];
        i_arr_tag   <= {a_tag[o_arr_index][1], a_tag[o_arr_index][0]};
        i_arr_data  <= {a_data[o_arr_index][1], a_data[o_arr_index][0]};
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } txn_t;

    txn_t obs_q[$];
    txn_t exp_q[$];

    logic [31:0] mem_bk [logic [31:0]];
    logic [31:0] mdl_mem[logic [31:0]];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] bk_rd(input logic [31:0] a);
        return mem_bk.exists(a) ? mem_bk[a] : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    // ---------------- line-level reference model ----------------
    bit          m_v    [4][2];
    bit          m_dirty[4][2];
    logic [27:0] m_tag  [4][2];
    logic [31:0] m_data [4][2];
    int          m_lru  [4];

    task automatic mdl_clear();
        for (int s = 0; s < 4; s++) begin
            m_lru[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_v[s][w] = 0;
                m_dirty[s][w] = 0;
            end
        end
    endtask

    task automatic mdl_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input int rwb, input int rrd, input int md,
                           output logic [31:0] er, output int el, output int enw, output logic ed);
        logic [1:0]  ix;
        logic [27:0] tg;
        logic [31:0] la;
        int hw;
        int vic;
        ix = addr[3:2];
        tg = addr[31:4];
        la = {tg, ix, 2'b00};
        hw = -1;
        for (int w = 0; w < 2; w++)
            if (hw < 0 && m_v[ix][w] && m_tag[ix][w] == tg) hw = w;
        el = 3; enw = 0; er = '0; ed = 1'b0;
        if (hw >= 0) begin
            if (wr) begin
                m_data[ix][hw] = wd;
                m_dirty[ix][hw] = 1;
                enw = 1;
                ed = 1'b1;
            end else begin
                er = m_data[ix][hw];
            end
            m_lru[ix] = 1 - hw;
        end else begin
            if (!m_v[ix][0]) vic = 0;
            else if (!m_v[ix][1]) vic = 1;
            else vic = m_lru[ix];
            if (m_v[ix][vic] && m_dirty[ix][vic]) begin
                exp_q.push_back('{1'b1, {m_tag[ix][vic], ix, 2'b00}, m_data[ix][vic]});
                mdl_mem[{m_tag[ix][vic], ix, 2'b00}] = m_data[ix][vic];
                el += 1 + rwb;
            end
            if (wr) begin
                m_data[ix][vic] = wd;
                m_dirty[ix][vic] = 1;
                ed = 1'b1;
            end else begin
                exp_q.push_back('{1'b0, la, 32'h0});
                m_data[ix][vic] = mdl_rd(la);
                m_dirty[ix][vic] = 0;
                er = m_data[ix][vic];
                el += 2 + rrd + md;
            end
            m_v[ix][vic] = 1;
            m_tag[ix][vic] = tg;
            enw = 1;
            m_lru[ix] = 1 - vic;
        end
    endtask

    // ---------------- request driver with memory responder ----------------
    task automatic run_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input int rwb, input int rrd, input int md, input bit noise,
                           output logic [31:0] rdata, output int lat, output int nw, output logic wdirty);
        int   n, wcnt, mcnt, lim;
        bit   done, rd_pend;
        txn_t hold, cur;
        logic [31:0] rd_addr;
        @(negedge i_clk);
        chk("req_ready_idle", {63'h0, o_cpu_req_ready}, 64'h1);
        i_cpu_req_valid = 1'b1;
        i_cpu_req_write = wr;
        i_cpu_req_addr  = addr;
        i_cpu_req_wdata = wd;
        @(posedge i_clk);
        #1;
        i_cpu_req_valid = 1'b0;
        n = 0; wcnt = 0; mcnt = 0; done = 0; rd_pend = 0; nw = 0;
        rdata = '0; lat = -1; wdirty = 1'b0; hold = '0; rd_addr = '0;
        while (!done && n < 100) begin
            @(negedge i_clk);
            n++;
            i_mem_req_ready  = 1'b0;
            i_mem_resp_valid = 1'b0;
            i_mem_resp_rdata = $urandom;
            if (o_cpu_resp_valid) begin
                rdata = o_cpu_resp_rdata;
                lat = n;
                done = 1;
            end else if (o_mem_req_valid) begin
                cur = '{o_mem_req_write, o_mem_req_addr, o_mem_req_write ? o_mem_req_wdata : 32'h0};
                chk("req_ready_busy", {63'h0, o_cpu_req_ready}, 64'h0);
                if (wcnt == 0) hold = cur;
                else chk("mem_req_stable", {31'h0, cur}, {31'h0, hold});
                lim = o_mem_req_write ? rwb : rrd;
                if (wcnt >= lim) begin
                    i_mem_req_ready = 1'b1;
                    obs_q.push_back(cur);
                    if (cur.w) mem_bk[cur.a] = cur.d;
                    else begin
                        rd_pend = 1;
                        mcnt = 0;
                        rd_addr = cur.a;
                    end
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else if (rd_pend) begin
                if (mcnt >= md) begin
                    i_mem_resp_valid = 1'b1;
                    i_mem_resp_rdata = bk_rd(rd_addr);
                    rd_pend = 0;
                end else begin
                    mcnt++;
                end
            end else if (noise && $urandom_range(3) == 0) begin
                i_mem_resp_valid = 1'b1;
            end
            #1;
            if (o_arr_write_en) begin
                nw++;
                wdirty = o_arr_dirty_in;
                chk("arr_v_in", {63'h0, o_arr_v_in}, 64'h1);
            end
        end
        i_mem_req_ready  = 1'b0;
        i_mem_resp_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_err++;
            $display("FAIL resp_timeout: got no response after %0d cycles, required one", n);
        end
    endtask

    task automatic do_one(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int rwb, input int rrd, input int md, input bit noise,
                          output logic [31:0] rdata, output int lat, output int ntx);
        logic [31:0] er;
        int el, enw, nw;
        logic ed, wdirty;
        obs_q.delete();
        exp_q.delete();
        mdl_req(wr, addr, wd, rwb, rrd, md, er, el, enw, ed);
        run_req(wr, addr, wd, rwb, rrd, md, noise, rdata, lat, nw, wdirty);
        chk("resp_rdata", {32'h0, rdata}, {32'h0, er});
        chk("latency", 64'(lat), 64'(el));
        chk("arr_writes", 64'(nw), 64'(enw));
        if (enw == 1 && nw == 1) chk("arr_dirty_in", {63'h0, wdirty}, {63'h0, ed});
        chk("mem_txn_count", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk("mem_txn", {31'h0, obs_q[i]}, {31'h0, exp_q[i]});
        ntx = obs_q.size();
    endtask

    task automatic clear_all();
        @(negedge i_clk);
        tb_clr = 1'b1;
        i_rst  = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        tb_clr = 1'b0;
        i_rst  = 1'b0;
        mdl_clear();
    endtask

    typedef struct {
        bit          clr;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        int          rwb;
        int          rrd;
        int          md;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_ntx;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] rdata;
        int lat, ntx, k;
        logic [31:0] ra;

        vecs[0] = '{0, 1'b0, 32'h10, 32'h0,    0, 0, 3, 32'hDEAD_BEEF, 8,  1};
        vecs[1] = '{0, 1'b0, 32'h10, 32'h0,    0, 0, 0, 32'hDEAD_BEEF, 3,  0};
        vecs[2] = '{0, 1'b1, 32'h20, 32'h1234, 0, 0, 0, 32'h0,         3,  0};
        vecs[3] = '{0, 1'b0, 32'h20, 32'h0,    0, 0, 0, 32'h1234,      3,  0};
        vecs[4] = '{1, 1'b0, 32'h00, 32'h0,    0, 0, 1, 32'h5A5A_0000, 6,  1};
        vecs[5] = '{0, 1'b0, 32'h40, 32'h0,    0, 2, 0, 32'h5A5A_0040, 7,  1};
        vecs[6] = '{0, 1'b1, 32'h00, 32'hCAFE_0001, 0, 0, 0, 32'h0,    3,  0};
        vecs[7] = '{0, 1'b0, 32'h40, 32'h0,    0, 0, 0, 32'h5A5A_0040, 3,  0};
        vecs[8] = '{0, 1'b0, 32'h80, 32'h0,    5, 0, 0, 32'h5A5A_0080, 11, 2};
        vecs[9] = '{0, 1'b0, 32'h00, 32'h0,    0, 0, 0, 32'hCAFE_0001, 5,  1};

        mem_bk[32'h10]  = 32'hDEAD_BEEF;
        mdl_mem[32'h10] = 32'hDEAD_BEEF;

        clear_all();
        #1;
        chk("rst_req_ready",  {63'h0, o_cpu_req_ready},  64'h1);
        chk("rst_resp_valid", {63'h0, o_cpu_resp_valid}, 64'h0);
        chk("rst_resp_rdata", {32'h0, o_cpu_resp_rdata}, 64'h0);
        chk("rst_mem_valid",  {63'h0, o_mem_req_valid},  64'h0);
        chk("rst_mem_addr",   {32'h0, o_mem_req_addr},   64'h0);
        chk("rst_arr_we",     {63'h0, o_arr_write_en},   64'h0);
        chk("rst_arr_index",  {62'h0, o_arr_index},      64'h0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].clr) clear_all();
            do_one(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].rwb, vecs[i].rrd, vecs[i].md,
                   1'b0, rdata, lat, ntx);
            chk("vec_rdata", {32'h0, rdata}, {32'h0, vecs[i].exp_rdata});
            chk("vec_latency", 64'(lat), 64'(vecs[i].exp_lat));
            chk("vec_ntx", 64'(ntx), 64'(vecs[i].exp_ntx));
        end

        // Reset while waiting for refill data; the late data beat must be dropped.
        clear_all();
        @(negedge i_clk);
        i_cpu_req_valid = 1'b1;
        i_cpu_req_write = 1'b0;
        i_cpu_req_addr  = 32'h1C;
        @(posedge i_clk);
        #1;
        i_cpu_req_valid = 1'b0;
        k = 0;
        do begin
            @(negedge i_clk);
            k++;
        end while (!o_mem_req_valid && k < 20);
        chk("rstmid_refill_req", {63'h0, o_mem_req_valid}, 64'h1);
        i_mem_req_ready = 1'b1;
        @(negedge i_clk);
        i_mem_req_ready = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        i_mem_resp_valid = 1'b1;
        i_mem_resp_rdata = 32'h0BAD_0BAD;
        #1;
        chk("rstmid_arr_we",     {63'h0, o_arr_write_en},  64'h0);
        chk("rstmid_mem_valid",  {63'h0, o_mem_req_valid}, 64'h0);
        chk("rstmid_req_ready",  {63'h0, o_cpu_req_ready}, 64'h1);
        @(negedge i_clk);
        i_mem_resp_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("rstmid_no_resp", {63'h0, o_cpu_resp_valid}, 64'h0);
            chk("rstmid_no_we",   {63'h0, o_arr_write_en},   64'h0);
            @(negedge i_clk);
        end
        mdl_clear();
        do_one(1'b0, 32'h1C, 32'h0, 0, 0, 0, 1'b0, rdata, lat, ntx);

        // Random traffic over a few tags per set so hits, evictions and writebacks all occur.
        for (int i = 0; i < 200; i++) begin
            ra = ($urandom_range(5) << 4) | ($urandom_range(3) << 2);
            do_one(1'($urandom_range(1)), ra, $urandom, $urandom_range(3), $urandom_range(3),
                   $urandom_range(3), 1'b1, rdata, lat, ntx);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
